// File: rtl/reg_dump_reader.sv
// Register dump reader: walks a latched mask over the register file read
// port and streams each selected register out as an (addr, data) beat.
module reg_dump_reader #(
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = 5,
  parameter int DATA_W   = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [NUM_REGS-1:0] reg_mask,
  output logic [ADDR_W-1:0]   rf_addr,
  input  logic [DATA_W-1:0]   rf_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [ADDR_W-1:0]   out_addr,
  output logic [DATA_W-1:0]   out_data,
  output logic                busy,
  output logic                done
);

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    HOLD,
    DONE
  } state_t;

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NUM_REGS - 1);

  state_t              state;
  logic [ADDR_W-1:0]   ptr;
  logic [NUM_REGS-1:0] maskQ;

  logic isLast;
  logic selHit;

  assign rf_addr = ptr;
  assign isLast  = (ptr == LAST);
  assign selHit  = maskQ[ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ptr       <= '0;
      maskQ     <= '0;
      out_valid <= 1'b0;
      out_addr  <= '0;
      out_data  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            maskQ <= reg_mask;
            ptr   <= '0;
            busy  <= 1'b1;
            state <= SCAN;
          end
        end
        SCAN: begin
          // rf_data is combinational on ptr, so capture it this cycle
          if (selHit) begin
            out_data  <= rf_data;
            out_addr  <= ptr;
            out_valid <= 1'b1;
            state     <= HOLD;
          end else if (isLast) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= DONE;
          end else begin
            ptr <= ptr + 1'b1;
          end
        end
        HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (isLast) begin
              done  <= 1'b1;
              busy  <= 1'b0;
              state <= DONE;
            end else begin
              ptr   <= ptr + 1'b1;
              state <= SCAN;
            end
          end
        end
        DONE: begin
          done  <= 1'b0;
          ptr   <= '0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/reg_dump_reader.md
Name: reg_dump_reader

Overview:
- Hardware replacement for simulation-only register dumps.
- Sits on a register file read port as the reader side of that interface.
- On a start pulse, walks register addresses under a latched select mask and reads each selected register through the combinational read port.
- Streams each result as an (address, data) beat over a valid/ready output interface, for a debug UART or trace buffer.

Parameters:
- NUM_REGS, 32: number of registers scanned (addresses 0..NUM_REGS-1).
- ADDR_W, 5: register address width; must satisfy 2**ADDR_W >= NUM_REGS.
- DATA_W, 32: register data width.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle request to begin a dump; sampled only in IDLE.
- reg_mask  input  NUM_REGS  bit i set = dump register i; latched when start is accepted.
- rf_addr  output  ADDR_W  drives the register file read address.
- rf_data  input  DATA_W  combinational read data returned for rf_addr.
- out_valid  output  1  output beat available.
- out_ready  input  1  downstream accepts the beat.
- out_addr  output  ADDR_W  register index of the current beat.
- out_data  output  DATA_W  register value of the current beat.
- busy  output  1  high from start acceptance until the DONE state.
- done  output  1  one-cycle pulse when the dump completes.

Behaviour:
- Reset (async assert, sync release): state=IDLE, ptr=0, mask_q=0, out_valid=0, out_addr=0, out_data=0, busy=0, done=0. rf_addr=ptr, so it reads 0.
- rf_addr is always driven as ptr (registered pointer). rf_data is sampled in the same cycle.
- IDLE:
  - start=1 latches mask_q<=reg_mask and ptr<=0, sets busy, and goes to SCAN.
  - start=0: stay in IDLE.
- SCAN, ptr=p:
  - If mask_q[p]=1: out_data<=rf_data, out_addr<=p, out_valid<=1, go to HOLD.
  - Else if p==NUM_REGS-1: go to DONE.
  - Else: ptr<=p+1 and stay in SCAN. Each skipped register costs one cycle.
- HOLD:
  - out_valid=1 while in HOLD; out_addr and out_data are held stable until the handshake.
  - On out_valid&&out_ready: out_valid<=0. If ptr==NUM_REGS-1, go to DONE; else ptr<=ptr+1 and go to SCAN.
  - Without out_ready, stay in HOLD indefinitely.
- DONE: done=1 and busy<=0 for exactly one cycle, ptr<=0, then go to IDLE.
- Latency:
  - start accepted at edge N puts the FSM in SCAN from N+1.
  - With first selected index k, out_valid rises after edge N+2+k.
  - With an always-ready sink, each selected register costs 2 cycles (SCAN+HOLD); each unselected register costs 1 cycle.
- Boundary conditions:
  - start while busy: ignored; mask_q is not updated.
  - reg_mask=0: scans all NUM_REGS entries with no beats. done pulses at the cycle N+1+NUM_REGS (33 cycles after start acceptance for 32 regs).
  - ptr never wraps; the last index always exits to DONE.
  - Data is sampled at SCAN time. Register writes after that sample do not alter a held beat. Writes to not-yet-scanned registers are reflected.
  - Register 0 is read through the port like any other register. The register file returns 0 for it.
  - rst_n asserted mid-dump: immediate return to reset values; any pending beat is dropped and no done pulse is produced.
  - out_ready asserted when out_valid=0 has no effect.

Test Plan:
- Preload R2=0x11, R3=0x22, R7=0x77; mask=0x0000_008C; out_ready=1 → beats (2,0x11),(3,0x22),(7,0x77) in order. done pulses once, after the last register scan. busy is low afterwards.
- mask=0xFFFF_FFFF with all regs = index*4 → 32 beats with out_data=4*addr. Beat for addr 0 carries 0. No gaps beyond 1 cycle per beat.
- mask=0x0000_0010, out_ready held 0 for 10 cycles after out_valid → out_valid, out_addr=4 and out_data stay stable 10 cycles. A write to R4 during the stall does not change out_data. Completes after ready.
- mask=0 → no out_valid. done pulses exactly 33 cycles after start is accepted.
- Pulse start again mid-dump with a different mask → ignored; original beat sequence unchanged.
- Assert rst_n=0 while in HOLD → out_valid, busy, done drop to 0 immediately (before the next edge). A new start after release restarts from addr 0.
